// File: rtl/fp_mult_scheduler.sv
// Round-robin scheduler sharing one pipelined FP multiplier among N_REQ requesters,
// with ID tagging and a halt/drain FSM. Define FP_MULT_SCHED_PERF_EN to add perf counters.
module fp_mult_scheduler #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int MULT_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                mult_load,
    output logic [31:0]         mult_a,
    output logic [31:0]         mult_b,
    input  logic [31:0]         mult_result,
    output logic                resp_valid,
    output logic [ID_W-1:0]     resp_id,
    output logic [31:0]         resp_data,
    input  logic                halt,
    output logic                halted,
    output logic                busy
`ifdef FP_MULT_SCHED_PERF_EN
    ,
    input  logic                perf_clr,
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_stall
`endif
);

    localparam int STAGES = MULT_LATENCY + 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    state_e                      state_q, state_d;
    logic [ID_W-1:0]             ptr_q, ptr_d;
    logic [STAGES-1:0]           tag_v_q, tag_v_d;
    logic [STAGES-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic                        mult_load_q, mult_load_d;
    logic [31:0]                 mult_a_q, mult_a_d;
    logic [31:0]                 mult_b_q, mult_b_d;
    logic                        resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]             resp_id_q, resp_id_d;
    logic [31:0]                 resp_data_q, resp_data_d;

    logic                        grant_en;
    logic                        found;
    logic                        accept;
    logic [ID_W-1:0]             grant_id;
    logic [ID_W-1:0]             cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt) state_d = DRAIN;
            DRAIN: begin
                if (!halt)                           state_d = RUN;
                else if (!busy && !resp_valid_q)     state_d = HALTED;
            end
            HALTED:  if (!halt) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Grants are also masked while reset is asserted so req_ready reads zero then.
    always_comb begin
        grant_en = rst_n && (state_q == RUN) && !halt;
        halted   = (state_q == HALTED);
    end

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ID_W'((32'(ptr_q) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
        req_ready = (grant_en && found) ? (N_REQ'(1) << grant_id) : '0;
        accept    = |(req_valid & req_ready);
    end

    always_comb begin
        ptr_d       = ptr_q;
        mult_load_d = accept;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        if (accept) begin
            ptr_d    = ID_W'((32'(grant_id) + 1) % N_REQ);
            mult_a_d = req_a[32*grant_id +: 32];
            mult_b_d = req_b[32*grant_id +: 32];
        end
        tag_v_d      = {tag_v_q[STAGES-2:0], accept};
        tag_id_d     = {tag_id_q[STAGES-2:0], grant_id};
        resp_valid_d = tag_v_q[STAGES-1];
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        if (tag_v_q[STAGES-1]) begin
            resp_id_d   = tag_id_q[STAGES-1];
            resp_data_d = mult_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            mult_load_q  <= 1'b0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            mult_load_q  <= mult_load_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign mult_load  = mult_load_q;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = (|tag_v_q) | mult_load_q;

`ifdef FP_MULT_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q + 32'(accept);
        perf_stall_d  = perf_stall_q + 32'(|(req_valid & ~req_ready));
        if (perf_clr) begin
            perf_issued_d = '0;
            perf_stall_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: doc/fp_mult_scheduler.md
Name: fp_mult_scheduler

Overview:
- Shares one pipelined single-precision floating_multiplier datapath among N requesters.
- Round-robin arbitration: at most one operand pair issued per cycle.
- Tags each issued operation with the requester ID through a shift pipeline matched to the multiplier latency, and returns each product with its ID.
- Provides a halt/drain FSM so software-side control can quiesce the multiplier before reconfiguration or test.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must satisfy 2^ID_W >= N_REQ.
- MULT_LATENCY, 2, edges from the multiplier sampling mult_load to mult_result valid. The sampling edge counts as the first edge.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand-pair valid.
- req_a  in  32*N_REQ  operand A for requester i, in bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B for requester i, same packing.
- req_ready  out  N_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
- mult_load  out  1  registered issue strobe to the multiplier.
- mult_a  out  32  registered operand A.
- mult_b  out  32  registered operand B.
- mult_result  in  32  multiplier product.
- resp_valid  out  1  one-cycle pulse: product available.
- resp_id  out  ID_W  requester that owns resp_data.
- resp_data  out  32  product.
- halt  in  1  level: stop granting new requests.
- halted  out  1  high when halted and the pipeline is empty.
- busy  out  1  high when any operation is in flight.

Behaviour:
- Reset (async, rst_n=0): req_ready=0, mult_load=0, mult_a=0, mult_b=0, resp_valid=0, resp_id=0, resp_data=0, halted=0, busy=0. RR pointer=0, tag pipeline cleared, FSM=RUN. In-flight operations are discarded; no response is ever produced for them.
- Arbitration, combinational, only in RUN:
  - Grant goes to the first i with req_valid[i]=1, searching from the pointer upward and wrapping modulo N_REQ.
  - req_ready is one-hot, or all zero if no request is valid.
  - req_ready never depends on resp or halt timing beyond the current state.
- On accept at edge E0:
  - mult_a/mult_b take the granted operands, mult_load=1 for exactly the next cycle, tag {1, id} enters pipeline stage 0.
  - Pointer becomes (grant+1) mod N_REQ.
  - With no accept, mult_load=0, mult_a/mult_b hold their values, and the pointer holds.
- Tag pipeline: MULT_LATENCY+1 stages, shifting every cycle. When the last stage is valid, at that edge resp_data<=mult_result, resp_id<=tag id, resp_valid<=1; otherwise resp_valid<=0.
- Latency: resp_valid is high in the cycle after edge E(MULT_LATENCY+1). With the default, that is 3 edges after accept.
- Throughput: 1 per cycle. Back-to-back responses return in acceptance order. There is no response backpressure; requesters must always sink.
- busy = OR of all tag-pipeline valid bits and mult_load.
- FSM states:
  - RUN: grants enabled. halt=1 → DRAIN (a grant is suppressed in the same cycle halt is sampled high; req_ready is 0 combinationally while halt=1).
  - DRAIN: no grants. busy=0 and resp_valid=0 → HALTED. halt=0 → RUN.
  - HALTED: halted=1, no grants. halt=0 → RUN; halted drops in the same edge.
- Simultaneous events:
  - halt rising in the same cycle as req_valid: no accept.
  - A single requester holding valid continuously is granted every cycle.
  - All requesters valid: grants rotate 0,1,2,3,0,...
- Operand values are not inspected; NaN, Inf and zero pass through unchanged.

Optional Feature:
- FP_MULT_SCHED_PERF_EN defined: adds ports perf_clr (in, 1), perf_issued (out, 32) and perf_stall (out, 32).
  - perf_issued increments on each accept.
  - perf_stall increments in each cycle where |(req_valid & ~req_ready) is true.
  - Both counters wrap at 2^32, reset to 0, and are cleared synchronously by perf_clr. Clear has priority over increment.
- FP_MULT_SCHED_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single req: req_valid=0001, a=0x40000000 (2.0), b=0x40400000 (3.0), model returns 0x40C00000 → resp_valid 3 edges after accept, resp_id=0, resp_data=0x40C00000, busy falls after.
- All four valid for 8 cycles → req_ready sequence 0001,0010,0100,1000,0001,...; 8 responses with ids 0,1,2,3,0,1,2,3 on consecutive cycles.
- req_valid=0101 held, pointer at 1 → grants alternate 2,0,2,0; requesters 1 and 3 are never granted.
- 3 ops in flight, halt=1 → no further req_ready; all 3 responses are delivered; halted=1 one cycle after the last resp_valid. halt=0 → grant resumes the next cycle.
- rst_n low mid-stream with 2 ops in flight → outputs zero immediately; no stale resp_valid after release; first grant goes to requester 0.
- FP_MULT_SCHED_PERF_EN: 10 accepts plus 5 blocked-requester cycles → perf_issued=10, perf_stall=5; perf_clr → both 0 the next cycle.
